// File: rtl/panel_scan_sequencer_if.sv
//------------------------------------------------------------------------------
// Module : panel_scan_sequencer_if
// Brief  : Control/strobe bundle between the scan sequencer and panel drivers.
//          PANEL_SCAN_FRAME_SYNC_EN adds the frame_swap_req/frame_swap_ack pair.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface panel_scan_sequencer_if;
    logic       enable;
    logic       brightness_req;
    logic       brightness_ack;
    logic [3:0] active_row_addr;
    logic [7:0] pwm_time;
    logic       load_led_vals;
    logic       load_brightness;
    logic       shift;
    logic       panel_latch;
    logic       row_blank;
    logic       frame_start;
`ifdef PANEL_SCAN_FRAME_SYNC_EN
    logic       frame_swap_req;
    logic       frame_swap_ack;
`endif

    modport master (
        input  enable,
        input  brightness_req,
`ifdef PANEL_SCAN_FRAME_SYNC_EN
        input  frame_swap_req,
        output frame_swap_ack,
`endif
        output brightness_ack,
        output active_row_addr,
        output pwm_time,
        output load_led_vals,
        output load_brightness,
        output shift,
        output panel_latch,
        output row_blank,
        output frame_start
    );

    modport slave (
        output enable,
        output brightness_req,
`ifdef PANEL_SCAN_FRAME_SYNC_EN
        output frame_swap_req,
        input  frame_swap_ack,
`endif
        input  brightness_ack,
        input  active_row_addr,
        input  pwm_time,
        input  load_led_vals,
        input  load_brightness,
        input  shift,
        input  panel_latch,
        input  row_blank,
        input  frame_start
    );
endinterface

`default_nettype wire

// File: rtl/panel_scan_sequencer.sv
//------------------------------------------------------------------------------
// Module : panel_scan_sequencer
// Brief  : Row/PWM-slot timing master for lockstep panel drivers, including the
//          brightness reload sequence. Optional: PANEL_SCAN_FRAME_SYNC_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module panel_scan_sequencer #(
    parameter int NUM_ROWS   = 16,
    parameter int PWM_STEPS  = 256,
    parameter int SHIFT_BITS = 16,
    parameter int SHIFT_DIV  = 2,
    parameter int ROW_SETTLE = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    panel_scan_sequencer_if.master bus
);

    localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam int BIT_W = $clog2(SHIFT_BITS + 1);
    localparam int SET_W = $clog2(ROW_SETTLE + 2);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SHIFT_BITS - 1);
    localparam logic [7:0]       PWM_LAST = 8'(PWM_STEPS - 1);
    localparam logic [3:0]       ROW_LAST = 4'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_BRIGHT_LOAD  = 3'd1,
        S_BRIGHT_SHIFT = 3'd2,
        S_BRIGHT_LATCH = 3'd3,
        S_SETTLE       = 3'd4,
        S_LOAD         = 3'd5,
        S_SHIFT        = 3'd6,
        S_LATCH        = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       row_q,   row_d;
    logic [7:0]       pwm_q,   pwm_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [BIT_W-1:0] bit_q,   bit_d;
    logic [SET_W-1:0] set_q,   set_d;
    logic             blank_q, blank_d;

    logic go_settle;
    logic load_led_vals;
    logic load_brightness;
    logic shift;
    logic panel_latch;
    logic brightness_ack;
    logic frame_start;
`ifdef PANEL_SCAN_FRAME_SYNC_EN
    logic frame_swap_ack;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= 4'd0;
            pwm_q   <= 8'd0;
            div_q   <= '0;
            bit_q   <= '0;
            set_q   <= '0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pwm_q   <= pwm_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            set_q   <= set_d;
            blank_q <= blank_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        pwm_d           = pwm_q;
        div_d           = div_q;
        bit_d           = bit_q;
        set_d           = set_q;
        blank_d         = blank_q;
        go_settle       = 1'b0;
        load_led_vals   = 1'b0;
        load_brightness = 1'b0;
        shift           = 1'b0;
        panel_latch     = 1'b0;
        brightness_ack  = 1'b0;
        frame_start     = 1'b0;
`ifdef PANEL_SCAN_FRAME_SYNC_EN
        frame_swap_ack  = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                blank_d = 1'b1;
                pwm_d   = 8'd0;
                if (bus.enable) begin
                    go_settle = 1'b1;
                end
            end

            S_SETTLE: begin
                if (set_q == '0) begin
                    state_d = S_LOAD;
                end else begin
                    set_d = set_q - SET_W'(1);
                end
            end

            S_LOAD: begin
                load_led_vals = 1'b1;
                div_d         = '0;
                bit_d         = '0;
                state_d       = S_SHIFT;
            end

            S_BRIGHT_LOAD: begin
                load_brightness = 1'b1;
                div_d           = '0;
                bit_d           = '0;
                state_d         = S_BRIGHT_SHIFT;
            end

            // Shared by both shift phases; only the exit state differs.
            S_SHIFT, S_BRIGHT_SHIFT: begin
                shift = (div_q == '0);
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = (state_q == S_SHIFT) ? S_LATCH : S_BRIGHT_LATCH;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_LATCH: begin
                panel_latch = 1'b1;
                if (pwm_q != PWM_LAST) begin
                    if (bus.enable) begin
                        pwm_d   = pwm_q + 8'd1;
                        blank_d = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        pwm_d   = 8'd0;
                        blank_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    pwm_d   = 8'd0;
                    blank_d = 1'b1;
                    if (!bus.enable) begin
                        // Row is held so a restart rescans the unfinished frame position.
                        state_d = S_IDLE;
                    end else begin
                        row_d = (row_q == ROW_LAST) ? 4'd0 : row_q + 4'd1;
                        if (bus.brightness_req) begin
                            state_d = S_BRIGHT_LOAD;
                        end else begin
                            go_settle = 1'b1;
                        end
                    end
                end
            end

            S_BRIGHT_LATCH: begin
                panel_latch    = 1'b1;
                brightness_ack = 1'b1;
                go_settle      = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_settle) begin
            state_d     = S_SETTLE;
            pwm_d       = 8'd0;
            blank_d     = 1'b1;
            set_d       = SET_W'(ROW_SETTLE - 1);
            frame_start = (row_d == 4'd0);
`ifdef PANEL_SCAN_FRAME_SYNC_EN
            // One extra blank clock gives upstream a clean bank-swap point.
            if ((row_d == 4'd0) && bus.frame_swap_req) begin
                set_d          = SET_W'(ROW_SETTLE);
                frame_swap_ack = 1'b1;
            end
`endif
        end
    end

    assign bus.active_row_addr = row_q;
    assign bus.pwm_time        = pwm_q;
    assign bus.load_led_vals   = load_led_vals;
    assign bus.load_brightness = load_brightness;
    assign bus.shift           = shift;
    assign bus.panel_latch     = panel_latch;
    assign bus.brightness_ack  = brightness_ack;
    assign bus.frame_start     = frame_start;
    // Panel is unblanked from the first latch of a row onwards.
    assign bus.row_blank       = (state_q == S_LATCH) ? 1'b0 : blank_q;
`ifdef PANEL_SCAN_FRAME_SYNC_EN
    assign bus.frame_swap_ack  = frame_swap_ack;
`endif

endmodule

`default_nettype wire
